pipe_hazard_ctl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline. It drives the ctl inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and the PC hold.
- It sequences multi-cycle multiplies held in EX, inserts load-use bubbles, squashes younger instructions on a taken leap, and drains the pipe on a trap reaching MEM.
- Stall and flush outputs are combinational from registered FSM state plus current-cycle inputs. They are consumed in the same cycle.

---
 rtl/pipe_hazard_ctl.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl
// ----------------------------------------------------------------------------
// Central stall/flush sequencer for the 5-stage pipeline. It holds the PC and
// the IF/ID and ID/EX registers while a multi-cycle multiply occupies EX. It
// inserts a bubble on a load-use hazard and squashes the two younger
// instructions on a taken leap. When a trap reaches MEM, it drains the whole
// pipe for TRAP_DRAIN cycles.
//
// Stall and flush outputs are combinational from the registered FSM state and
// the current-cycle inputs, so the pipeline registers consume them in the same
// cycle. The cause priority is trap > mul > leap > load-use. Only the winning
// cause drives the outputs, so a register never sees a stall and a flush
// together.
//
// Parameters:
//   MUL_LAT     total cycles a mul occupies EX (1..16); 1 means no stall
//   TRAP_DRAIN  flush cycles after a trap is seen in MEM (1..16)
//
// Ports:
//   clk, reset          pipeline clock, synchronous active-low reset
//   id_rs1/id_rs2       source registers of the ID instruction
//   id_uses_rs2         ID instruction reads rs2
//   ex_destReg          destination of the EX instruction
//   ex_RegWrite         EX instruction writes the GPR file
//   ex_MemToReg         EX instruction is a load
//   ex_mul              EX instruction is a mul
//   ex_leap             EX instruction is a taken jump/branch
//   mem_trap            MEM instruction is a trap
//   pc_stall            hold PC
//   if_id_stall         hold IF/ID
//   id_ex_stall         hold ID/EX
//   if_id_flush         bubble into IF/ID
//   id_ex_flush         bubble into ID/EX
//   ex_mem_flush        bubble into EX/MEM
//   mul_busy            FSM is in MUL
//   state               FSM state: 00 RUN, 01 MUL, 10 TRAP
// ----------------------------------------------------------------------------
module pipe_hazard_ctl #(
    parameter int MUL_LAT    = 5,
    parameter int TRAP_DRAIN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_destReg,
    input  logic       ex_RegWrite,
    input  logic       ex_MemToReg,
    input  logic       ex_mul,
    input  logic       ex_leap,
    input  logic       mem_trap,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mul_busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_MUL  = 2'b01,
        ST_TRAP = 2'b10
    } state_e;

    // A one-cycle mul needs no stall, so the MUL state is never entered.
    localparam bit MUL_ENABLED = (MUL_LAT > 1);

    // The entry cycle counts as the first busy cycle. MUL therefore runs
    // MUL_LAT-1 further cycles, and the last of them is the cnt==0 release
    // cycle.
    localparam logic [3:0] MUL_LOAD  = MUL_ENABLED ? 4'(MUL_LAT - 2) : 4'd0;

    // The entry cycle is the first flush cycle. TRAP counts the rest down
    // to 1.
    localparam logic [3:0] TRAP_LOAD = 4'(TRAP_DRAIN - 1);

    // With a single drain cycle, the entry cycle is the whole drain.
    localparam state_e TRAP_NEXT = (TRAP_DRAIN == 1) ? ST_RUN : ST_TRAP;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic w_load_use;
    logic w_eval_hazards;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_flush;

    // Register 0 is hard-wired, so a load to r0 never creates a dependency.
    assign w_load_use = ex_MemToReg && ex_RegWrite && (ex_destReg != 5'd0) &&
                        ((ex_destReg == id_rs1) ||
                         (id_uses_rs2 && (ex_destReg == id_rs2)));

    // Next-state and stall/flush decode, in trap > mul > leap > load-use order.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_eval_hazards = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;

        if (mem_trap) begin
            // A trap aborts a multiply and restarts an ongoing drain.
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_state_nxt    = TRAP_NEXT;
            w_cnt_nxt      = TRAP_LOAD;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (MUL_ENABLED && ex_mul) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_stall  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                        w_state_nxt    = ST_MUL;
                        w_cnt_nxt      = MUL_LOAD;
                    end else begin
                        w_eval_hazards = 1'b1;
                    end
                end
                ST_MUL: begin
                    if (r_cnt != 4'd0) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_stall  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                        w_cnt_nxt      = r_cnt - 4'd1;
                    end else begin
                        // The result moves on to EX/MEM. ex_mul is still high
                        // here but must not retrigger a multiply.
                        w_state_nxt    = ST_RUN;
                        w_cnt_nxt      = 4'd0;
                        w_eval_hazards = 1'b1;
                    end
                end
                ST_TRAP: begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end

        // A leap squashes the ID instruction, so its load-use stall is moot.
        if (w_eval_hazards) begin
            if (ex_leap) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end else begin
                w_pc_stall    = 1'b0;
            end
        end else begin
            w_eval_hazards = 1'b0;
        end
    end

    // FSM state and cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // While reset is low, every output is forced to 0.
    assign pc_stall     = reset & w_pc_stall;
    assign if_id_stall  = reset & w_if_id_stall;
    assign id_ex_stall  = reset & w_id_ex_stall;
    assign if_id_flush  = reset & w_if_id_flush;
    assign id_ex_flush  = reset & w_id_ex_flush;
    assign ex_mem_flush = reset & w_ex_mem_flush;
    assign mul_busy     = reset & (r_state == ST_MUL);
    assign state        = reset ? r_state : 2'b00;

    pipe_hazard_ctl_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .if_id_stall  (if_id_stall),
        .id_ex_stall  (id_ex_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mul_busy     (mul_busy),
        .state        (state)
    );

endmodule

// pipe_hazard_ctl_chk
// ----------------------------------------------------------------------------
// Structural invariants of the sequencer outputs. This module contains only
// assertions and drives nothing.
//
// Ports: clk/reset plus the observed controller outputs (all inputs).
// ----------------------------------------------------------------------------
module pipe_hazard_ctl_chk (
    input logic       clk,
    input logic       reset,
    input logic       if_id_stall,
    input logic       id_ex_stall,
    input logic       if_id_flush,
    input logic       id_ex_flush,
    input logic       mul_busy,
    input logic [1:0] state
);

    a_if_id_excl: assert property (@(posedge clk) disable iff (!reset)
        !(if_id_stall && if_id_flush));

    a_id_ex_excl: assert property (@(posedge clk) disable iff (!reset)
        !(id_ex_stall && id_ex_flush));

    a_busy_state: assert property (@(posedge clk) disable iff (!reset)
        (mul_busy == (state == 2'b01)));

    a_state_legal: assert property (@(posedge clk) disable iff (!reset)
        (state != 2'b11));

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Testbench for pipe_hazard_ctl. Two instances share the same inputs:
// u_dut5 (MUL_LAT=5, TRAP_DRAIN=3) and u_dut2 (MUL_LAT=2, TRAP_DRAIN=3).
// A reference model tracks the mul and trap occupancy as remaining cycle
// counts.
module tb_pipe_hazard_ctl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1 = 5'd0;
    logic [4:0] id_rs2 = 5'd0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] ex_destReg = 5'd0;
    logic       ex_RegWrite = 1'b0;
    logic       ex_MemToReg = 1'b0;
    logic       ex_mul = 1'b0;
    logic       ex_leap = 1'b0;
    logic       mem_trap = 1'b0;

    logic       pc5, ifs5, ids5, iff5, idf5, emf5, busy5;
    logic [1:0] st5;
    logic       pc2, ifs2, ids2, iff2, idf2, emf2, busy2;
    logic [1:0] st2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.MUL_LAT(5), .TRAP_DRAIN(3)) u_dut5 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_destReg(ex_destReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
        .ex_mul(ex_mul), .ex_leap(ex_leap), .mem_trap(mem_trap),
        .pc_stall(pc5), .if_id_stall(ifs5), .id_ex_stall(ids5),
        .if_id_flush(iff5), .id_ex_flush(idf5), .ex_mem_flush(emf5),
        .mul_busy(busy5), .state(st5)
    );

    pipe_hazard_ctl #(.MUL_LAT(2), .TRAP_DRAIN(3)) u_dut2 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_destReg(ex_destReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
        .ex_mul(ex_mul), .ex_leap(ex_leap), .mem_trap(mem_trap),
        .pc_stall(pc2), .if_id_stall(ifs2), .id_ex_stall(ids2),
        .if_id_flush(iff2), .id_ex_flush(idf2), .ex_mem_flush(emf2),
        .mul_busy(busy2), .state(st2)
    );

    // mul_left: cycles the mul still holds EX after the current cycle.
    // The value 1 marks the final (release) cycle.
    // trap_left: flush cycles still owed after the current cycle.
    typedef struct {
        int mul_left;
        int trap_left;
    } mstate_t;

    mstate_t m5 = '{0, 0};
    mstate_t m2 = '{0, 0};

    // Returns {pc,if_id_st,id_ex_st,if_id_fl,id_ex_fl,ex_mem_fl,busy,state[1:0]}.
    function automatic logic [8:0] model(input int lat, input int drain,
                                         input mstate_t s, output mstate_t n);
        logic pc, fs, ds, ff, df, ef, busy, lu;
        logic [1:0] st;
        pc = 1'b0; fs = 1'b0; ds = 1'b0; ff = 1'b0; df = 1'b0; ef = 1'b0;
        n = s;
        busy = (s.mul_left > 0);
        st = (s.trap_left > 0) ? 2'd2 : ((s.mul_left > 0) ? 2'd1 : 2'd0);
        lu = ex_MemToReg && ex_RegWrite && (ex_destReg != 5'd0) &&
             ((ex_destReg == id_rs1) || (id_uses_rs2 && (ex_destReg == id_rs2)));
        if (!reset) begin
            n.mul_left = 0; n.trap_left = 0; busy = 1'b0; st = 2'd0;
        end else if (mem_trap) begin
            ff = 1'b1; df = 1'b1; ef = 1'b1;
            n.trap_left = drain - 1; n.mul_left = 0;
        end else if (s.trap_left > 0) begin
            ff = 1'b1; df = 1'b1; ef = 1'b1;
            n.trap_left = s.trap_left - 1;
        end else if (s.mul_left > 1) begin
            pc = 1'b1; fs = 1'b1; ds = 1'b1; ef = 1'b1;
            n.mul_left = s.mul_left - 1;
        end else begin
            n.mul_left = 0;
            if ((s.mul_left == 0) && ex_mul && (lat > 1)) begin
                pc = 1'b1; fs = 1'b1; ds = 1'b1; ef = 1'b1;
                n.mul_left = lat - 1;
            end else if (ex_leap) begin
                ff = 1'b1; df = 1'b1;
            end else if (lu) begin
                pc = 1'b1; fs = 1'b1; df = 1'b1;
            end
        end
        return {pc, fs, ds, ff, df, ef, busy, st};
    endfunction

    // One clock cycle: sample at negedge against the model, then advance the
    // model at posedge.
    task automatic run_cycle(output logic [8:0] g5, output logic [8:0] e5,
                             output logic [8:0] g2, output logic [8:0] e2);
        mstate_t n5, n2;
        @(negedge clk);
        e5 = model(5, 3, m5, n5);
        e2 = model(2, 3, m2, n2);
        g5 = {pc5, ifs5, ids5, iff5, idf5, emf5, busy5, st5};
        g2 = {pc2, ifs2, ids2, iff2, idf2, emf2, busy2, st2};
        @(posedge clk);
        m5 = n5;
        m2 = n2;
        #1;
    endtask

    task automatic idle(input int n);
        logic [8:0] g5, e5, g2, e2;
        ex_mul = 1'b0; ex_leap = 1'b0; mem_trap = 1'b0;
        ex_MemToReg = 1'b0; ex_RegWrite = 1'b0;
        for (int i = 0; i < n; i++) begin
            run_cycle(g5, e5, g2, e2);
            if (g5 !== e5) begin errors++; $display("FAIL idle dut5 got %b exp %b", g5, e5); end
            if (g2 !== e2) begin errors++; $display("FAIL idle dut2 got %b exp %b", g2, e2); end
            checks += 2;
        end
    endtask

    task automatic test_reset();
        logic [8:0] g5, e5, g2, e2;
        reset = 1'b0; ex_mul = 1'b1; mem_trap = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_cycle(g5, e5, g2, e2);
            if (g5 !== 9'd0) begin errors++; $display("FAIL reset_dut5 got %b exp %b", g5, 9'd0); end
            if (g2 !== 9'd0) begin errors++; $display("FAIL reset_dut2 got %b exp %b", g2, 9'd0); end
            checks += 2;
        end
        reset = 1'b1; mem_trap = 1'b0;
        run_cycle(g5, e5, g2, e2);
        if (g5 !== 9'b111001000) begin errors++; $display("FAIL reset_release_mul got %b exp %b", g5, 9'b111001000); end
        if (g2 !== e2) begin errors++; $display("FAIL reset_release_dut2 got %b exp %b", g2, e2); end
        checks += 2;
        idle(6);
    endtask

    task automatic test_mul();
        logic [8:0] g5, e5, g2, e2;
        int stalls;
        stalls = 0;
        ex_mul = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) ex_mul = 1'b0;
            run_cycle(g5, e5, g2, e2);
            if (g5[8]) stalls++;
            if (g5[8] !== (c <= 4) || g5[7] !== (c <= 4) || g5[6] !== (c <= 4) || g5[3] !== (c <= 4)) begin
                errors++; $display("FAIL mul_stall cycle %0d got %b", c, g5);
            end
            if (g5[2] !== (c >= 2 && c <= 5)) begin
                errors++; $display("FAIL mul_busy cycle %0d got %b exp %b", c, g5[2], (c >= 2 && c <= 5));
            end
            if (g2 !== e2) begin errors++; $display("FAIL mul_dut2 cycle %0d got %b exp %b", c, g2, e2); end
            checks += 3;
        end
        if (g5[1:0] !== 2'b00) begin errors++; $display("FAIL mul_state_after got %b exp 00", g5[1:0]); end
        if (stalls !== 4) begin errors++; $display("FAIL mul_stall_count got %0d exp 4", stalls); end
        checks += 2;
        idle(2);
    endtask

    task automatic test_load_use();
        logic [8:0] g5, e5, g2, e2;
        ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_destReg = 5'd7;
        id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        run_cycle(g5, e5, g2, e2);
        if (g5 !== 9'b110010000) begin errors++; $display("FAIL load_use got %b exp %b", g5, 9'b110010000); end
        checks++;
        ex_destReg = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        run_cycle(g5, e5, g2, e2);
        if (g5 !== 9'd0) begin errors++; $display("FAIL load_use_r0 got %b exp %b", g5, 9'd0); end
        checks++;
        ex_destReg = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        run_cycle(g5, e5, g2, e2);
        if (g5 !== 9'd0) begin errors++; $display("FAIL load_use_no_rs2 got %b exp %b", g5, 9'd0); end
        if (g2 !== 9'd0) begin errors++; $display("FAIL load_use_no_rs2_dut2 got %b exp %b", g2, 9'd0); end
        checks += 2;
        idle(1);
    endtask

    task automatic test_leap_load_use();
        logic [8:0] g5, e5, g2, e2;
        ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_destReg = 5'd9;
        id_rs1 = 5'd9; id_uses_rs2 = 1'b0; ex_leap = 1'b1;
        run_cycle(g5, e5, g2, e2);
        if (g5 !== 9'b000110000) begin errors++; $display("FAIL leap_lu got %b exp %b", g5, 9'b000110000); end
        if (g2 !== 9'b000110000) begin errors++; $display("FAIL leap_lu_dut2 got %b exp %b", g2, 9'b000110000); end
        checks += 2;
        idle(1);
    endtask

    task automatic test_trap_in_mul();
        logic [8:0] g5, e5, g2, e2;
        logic [8:0] exp_t [0:5];
        exp_t[0] = 9'b111001000;
        exp_t[1] = 9'b111001101;
        exp_t[2] = 9'b000111101;
        exp_t[3] = 9'b000111010;
        exp_t[4] = 9'b000111010;
        exp_t[5] = 9'b000000000;
        ex_mul = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mem_trap = (c == 2);
            if (c == 5) ex_mul = 1'b0;
            run_cycle(g5, e5, g2, e2);
            if (g5 !== exp_t[c]) begin errors++; $display("FAIL trap_in_mul cycle %0d got %b exp %b", c + 1, g5, exp_t[c]); end
            if (g2 !== e2) begin errors++; $display("FAIL trap_dut2 cycle %0d got %b exp %b", c + 1, g2, e2); end
            checks += 2;
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [8:0] g5, e5, g2, e2;
        ex_mul = 1'b1;
        for (int c = 0; c < 6; c++) begin
            run_cycle(g5, e5, g2, e2);
            if (g2[8] !== ((c % 2) == 0) || g2[1:0] !== ((c % 2) == 0 ? 2'b00 : 2'b01)) begin
                errors++; $display("FAIL back_to_back cycle %0d got %b", c + 1, g2);
            end
            if (g5 !== e5) begin errors++; $display("FAIL back_to_back_dut5 cycle %0d got %b exp %b", c + 1, g5, e5); end
            checks += 2;
        end
        idle(6);
    endtask

    task automatic test_random();
        logic [8:0] g5, e5, g2, e2;
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 59) != 0);
            mem_trap    = ($urandom_range(0, 24) == 0);
            ex_mul      = ($urandom_range(0, 3) == 0);
            ex_leap     = ($urandom_range(0, 4) == 0);
            ex_MemToReg = $urandom_range(0, 1);
            ex_RegWrite = ($urandom_range(0, 3) != 0);
            ex_destReg  = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_uses_rs2 = $urandom_range(0, 1);
            run_cycle(g5, e5, g2, e2);
            if (g5 !== e5) begin errors++; $display("FAIL random dut5 iter %0d got %b exp %b", i, g5, e5); end
            if (g2 !== e2) begin errors++; $display("FAIL random dut2 iter %0d got %b exp %b", i, g2, e2); end
            checks += 2;
        end
        reset = 1'b1;
        idle(6);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_load_use();
        test_leap_load_use();
        test_trap_in_mul();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
